// File: rtl/bcd_display_pkg.sv
// Shared constants for the multiplexed 2-digit display: active-low segment
// patterns, anode codes and the scan FSM state encoding.
package bcd_display_pkg;

    localparam logic [6:0] SEG_0    = 7'h40;
    localparam logic [6:0] SEG_1    = 7'h79;
    localparam logic [6:0] SEG_2    = 7'h24;
    localparam logic [6:0] SEG_3    = 7'h30;
    localparam logic [6:0] SEG_4    = 7'h19;
    localparam logic [6:0] SEG_5    = 7'h12;
    localparam logic [6:0] SEG_6    = 7'h02;
    localparam logic [6:0] SEG_7    = 7'h78;
    localparam logic [6:0] SEG_8    = 7'h00;
    localparam logic [6:0] SEG_9    = 7'h10;
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

    localparam logic [1:0] AN_OFF   = 2'b11;
    localparam logic [1:0] AN_UNITS = 2'b10;
    localparam logic [1:0] AN_TENS  = 2'b01;

    typedef enum logic [1:0] {
        BLANK_U = 2'd0,
        SHOW_U  = 2'd1,
        BLANK_D = 2'd2,
        SHOW_D  = 2'd3
    } state_t;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-low 7-segment decoder; non-BCD codes show a dash.
module bcd_to_7seg
    import bcd_display_pkg::*;
#(
    parameter int NBITS = 4
) (
    input  logic [NBITS-1:0] i_digit,
    output logic [6:0]       o_seg
);

    always_comb begin
        o_seg = SEG_DASH;
        case (i_digit)
            NBITS'(0): o_seg = SEG_0;
            NBITS'(1): o_seg = SEG_1;
            NBITS'(2): o_seg = SEG_2;
            NBITS'(3): o_seg = SEG_3;
            NBITS'(4): o_seg = SEG_4;
            NBITS'(5): o_seg = SEG_5;
            NBITS'(6): o_seg = SEG_6;
            NBITS'(7): o_seg = SEG_7;
            NBITS'(8): o_seg = SEG_8;
            NBITS'(9): o_seg = SEG_9;
            default:   o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_display_mux.sv
// Two-digit multiplexed common-anode display driver with per-slot blanking guard,
// once-per-frame digit snapshot and optional leading-zero suppression.
module bcd_display_mux
    import bcd_display_pkg::*;
#(
    parameter int NBITS        = 4,
    parameter int DIGIT_CYCLES = 25000,
    parameter int BLANK_CYCLES = 500,
    parameter int LZ_BLANK     = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [NBITS-1:0] counter_u,
    input  logic [NBITS-1:0] counter_d,
    output logic [6:0]       seg,
    output logic [1:0]       an,
    output logic             frame_start
);

    localparam int CW = $clog2(DIGIT_CYCLES);
    localparam logic [CW-1:0] SLOT_LAST  = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    logic [CW-1:0]    r_count;
    state_t           r_state;
    state_t           w_stateNext;
    logic             r_first;
    logic [NBITS-1:0] r_snapU;
    logic [NBITS-1:0] r_snapD;
    logic [6:0]       r_seg;
    logic [1:0]       r_an;
    logic             r_frameStart;
    logic             w_slotEnd;
    logic             w_snapTake;
    logic [NBITS-1:0] w_digit;
    logic [6:0]       w_decSeg;
    logic [6:0]       w_segNext;
    logic [1:0]       w_anNext;

    assign w_slotEnd  = (r_count == SLOT_LAST);
    assign w_snapTake = r_first || (r_state == SHOW_D && w_slotEnd);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
            r_first <= 1'b1;
            r_snapU <= '0;
            r_snapD <= '0;
        end else begin
            r_count <= w_slotEnd ? '0 : r_count + CW'(1);
            r_first <= 1'b0;
            if (w_snapTake) begin
                r_snapU <= counter_u;
                r_snapD <= counter_d;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= BLANK_U;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            BLANK_U: if (r_count == BLANK_LAST) w_stateNext = SHOW_U;
            SHOW_U:  if (w_slotEnd)             w_stateNext = BLANK_D;
            BLANK_D: if (r_count == BLANK_LAST) w_stateNext = SHOW_D;
            SHOW_D:  if (w_slotEnd)             w_stateNext = BLANK_U;
            default:                            w_stateNext = BLANK_U;
        endcase
    end

    // One shared decoder; the tens snapshot is only routed to it in the tens slot.
    assign w_digit = (r_state == SHOW_D) ? r_snapD : r_snapU;

    bcd_to_7seg #(
        .NBITS(NBITS)
    ) u_decoder (
        .i_digit(w_digit),
        .o_seg  (w_decSeg)
    );

    always_comb begin
        w_segNext = SEG_OFF;
        w_anNext  = AN_OFF;
        if (enable) begin
            case (r_state)
                SHOW_U: begin
                    w_segNext = w_decSeg;
                    w_anNext  = AN_UNITS;
                end
                SHOW_D: begin
                    if (!(LZ_BLANK != 0 && r_snapD == '0)) begin
                        w_segNext = w_decSeg;
                        w_anNext  = AN_TENS;
                    end
                end
                default: begin
                    w_segNext = SEG_OFF;
                    w_anNext  = AN_OFF;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_seg        <= SEG_OFF;
            r_an         <= AN_OFF;
            r_frameStart <= 1'b0;
        end else begin
            r_seg        <= w_segNext;
            r_an         <= w_anNext;
            r_frameStart <= w_snapTake;
        end
    end

    assign seg         = r_seg;
    assign an          = r_an;
    assign frame_start = r_frameStart;

endmodule

// File: tb/tb_bcd_display_mux.sv
// Randomised scoreboard bench for bcd_display_mux: two instances (leading-zero
// blanking on and off) compared every cycle against a frame-position model.
module tb_bcd_display_mux;

    localparam int DC    = 8;
    localparam int BC    = 2;
    localparam int FRAME = 2 * DC;

    typedef struct packed {
        logic [6:0] seg;
        logic [1:0] an;
        logic       fs;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b1;
    logic [3:0] counterU = 4'd0;
    logic [3:0] counterD = 4'd0;
    logic [6:0] segLz, segNoLz;
    logic [1:0] anLz, anNoLz;
    logic       fsLz, fsNoLz;

    int nVectors = 0;
    int nMiscompares = 0;
    int k = 0;
    logic [3:0] mSnapU = 4'd0;
    logic [3:0] mSnapD = 4'd0;
    exp_t expLz[$];
    exp_t expNoLz[$];

    logic [6:0] decTab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

    always #5 clk = ~clk;

    bcd_display_mux #(.NBITS(4), .DIGIT_CYCLES(DC), .BLANK_CYCLES(BC), .LZ_BLANK(1)) dutLz (
        .clk(clk), .reset(reset), .enable(enable), .counter_u(counterU), .counter_d(counterD),
        .seg(segLz), .an(anLz), .frame_start(fsLz)
    );

    bcd_display_mux #(.NBITS(4), .DIGIT_CYCLES(DC), .BLANK_CYCLES(BC), .LZ_BLANK(0)) dutNoLz (
        .clk(clk), .reset(reset), .enable(enable), .counter_u(counterU), .counter_d(counterD),
        .seg(segNoLz), .an(anNoLz), .frame_start(fsNoLz)
    );

    function automatic void compare(string name, int act, int req);
        nVectors++;
        if (act != req) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (edge %0d)", name, act, req, k);
        end
    endfunction

    // What the display should show for a given position in the frame.
    function automatic exp_t modelOut(int pos, logic en, logic [3:0] su, logic [3:0] sd, bit lz);
        exp_t e;
        e.seg = 7'h7F;
        e.an  = 2'b11;
        e.fs  = 1'b0;
        if (en) begin
            if (pos >= BC && pos < DC) begin
                e.seg = decTab[su];
                e.an  = 2'b10;
            end else if (pos >= DC + BC && pos < FRAME && !(lz && sd == 4'd0)) begin
                e.seg = decTab[sd];
                e.an  = 2'b01;
            end
        end
        return e;
    endfunction

    task automatic applyStimulus(input int n);
        exp_t eL, eN;
        bit take;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            k++;
            take = (k == 1) || (k % FRAME == 0);
            eL = modelOut((k - 1) % FRAME, enable, mSnapU, mSnapD, 1'b1);
            eN = modelOut((k - 1) % FRAME, enable, mSnapU, mSnapD, 1'b0);
            eL.fs = take;
            eN.fs = take;
            expLz.push_back(eL);
            expNoLz.push_back(eN);
            if (take) begin
                mSnapU = counterU;
                mSnapD = counterD;
            end
            #1;
        end
    endtask

    task automatic checkOutput(string tag, logic [6:0] s, logic [1:0] a, logic f, exp_t e);
        compare({tag, ".seg"}, int'(s), int'(e.seg));
        compare({tag, ".an"}, int'(a), int'(e.an));
        compare({tag, ".frame_start"}, int'(f), int'(e.fs));
    endtask

    task automatic checkReset(string tag);
        exp_t e;
        e.seg = 7'h7F;
        e.an  = 2'b11;
        e.fs  = 1'b0;
        checkOutput({tag, ".lz"}, segLz, anLz, fsLz, e);
        checkOutput({tag, ".nolz"}, segNoLz, anNoLz, fsNoLz, e);
    endtask

    task automatic applyReset();
        expLz.delete();
        expNoLz.delete();
        reset = 1'b0;
        #1;
        checkReset("resetImmediate");
        repeat (10) @(posedge clk);
        @(negedge clk);
        checkReset("resetHold");
        reset = 1'b1;
        k = 0;
        mSnapU = 4'd0;
        mSnapD = 4'd0;
    endtask

    task automatic alignTo(input int pos);
        for (int i = 0; i < FRAME && (k % FRAME) != pos; i++) applyStimulus(1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (expLz.size() > 0) begin
            e = expLz.pop_front();
            checkOutput("lz", segLz, anLz, fsLz, e);
        end
        if (expNoLz.size() > 0) begin
            e = expNoLz.pop_front();
            checkOutput("nolz", segNoLz, anNoLz, fsNoLz, e);
        end
    end

    initial begin
        logic [3:0] chainU, chainD;
        #2;
        counterU = 4'd4;
        counterD = 4'd7;
        applyReset();
        $display("[TB] static 4,7");
        applyStimulus(40);

        $display("[TB] leading zero 5,0");
        counterU = 4'd5;
        counterD = 4'd0;
        applyStimulus(34);

        $display("[TB] tearing 3 -> 8 mid units slot");
        counterU = 4'd3;
        counterD = 4'd2;
        applyStimulus(16);
        alignTo(4);
        counterU = 4'd8;
        applyStimulus(30);

        $display("[TB] invalid digit and enable drop");
        counterU = 4'd12;
        counterD = 4'd9;
        applyStimulus(20);
        alignTo(5);
        enable = 1'b0;
        applyStimulus(2);
        enable = 1'b1;
        applyStimulus(30);

        $display("[TB] reset mid-frame");
        alignTo(11);
        counterU = 4'd1;
        counterD = 4'd3;
        applyReset();
        applyStimulus(20);

        $display("[TB] chained BCD counter");
        chainU = 4'd0;
        chainD = 4'd0;
        for (int i = 0; i < 100; i++) begin
            counterU = chainU;
            counterD = chainD;
            applyStimulus(3);
            if (chainU == 4'd9) begin
                chainU = 4'd0;
                chainD = (chainD == 4'd9) ? 4'd0 : chainD + 4'd1;
            end else begin
                chainU = chainU + 4'd1;
            end
        end

        $display("[TB] random stimulus");
        for (int i = 0; i < 60; i++) begin
            counterU = 4'($urandom_range(0, 15));
            counterD = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            enable   = ($urandom_range(0, 9) != 0);
            applyStimulus(int'($urandom_range(1, 8)));
        end
        enable = 1'b1;
        applyStimulus(4);
        @(negedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
